// File: rtl/decode_queue_pkg.sv
// Shared constants and helpers for the decode/execute control-bundle queue.
// The entry layout is {serial, excp, pc, ctrl}; widths are set by the user module.
package decode_queue_pkg;

    localparam int DQ_MIN_DEPTH = 2;
    localparam int DQ_CTRL_W_DEF = 96;
    localparam int DQ_PC_W_DEF = 32;

    // Default-width entry, for blocks that use the standard control word size
    typedef struct packed {
        logic                     serial;
        logic                     excp;
        logic [DQ_PC_W_DEF-1:0]   pc;
        logic [DQ_CTRL_W_DEF-1:0] ctrl;
    } dq_entry_t;

    // Pointer width for a power-of-two depth, never narrower than one bit
    function automatic int dq_ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decode_queue_mem.sv
// Entry storage for the decode queue: one write port, one asynchronous read port.
// Contents are never reset; validity is tracked entirely by the owning queue.
module decode_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 130,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/decode_ctrl_queue.sv
// Elastic decode->execute buffer with optional same-cycle bypass, flush and a
// serialising fence that stops younger bundles until the serial one drains.
module decode_ctrl_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 96,
    parameter int PC_W   = 32,
    parameter int BYPASS = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       in_excp,
    input  logic                       in_serial,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_excp,
    output logic                       out_serial,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = dq_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              serial;
        logic              excp;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ser_block_reg, ser_block_next;

    entry_t in_entry;
    entry_t rd_entry;
    entry_t head;
    logic   empty;
    logic   full;
    logic   bypass_path;
    logic   enq;
    logic   deq;
    logic   bypass_take;
    logic   store;
    logic   pop;

    assign in_entry = '{serial: in_serial, excp: in_excp, pc: in_pc, ctrl: in_ctrl};

    decode_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (CLK),
        .we    (store),
        .waddr (wr_ptr_reg),
        .wdata (in_entry),
        .raddr (rd_ptr_reg),
        .rdata (rd_entry)
    );

    // Handshake qualification; in_ready deliberately ignores out_ready
    always_comb begin
        empty       = (count_reg == '0);
        full        = (count_reg == CNT_W'(DEPTH));
        bypass_path = (BYPASS != 0) && empty;
        in_ready    = !RST && !full && !ser_block_reg && !flush;
        out_valid   = !RST && !flush && (!empty || (bypass_path && in_valid));
        head        = bypass_path ? in_entry : rd_entry;
        enq         = in_valid && in_ready;
        deq         = out_valid && out_ready;
        // A bundle taken straight through never touches storage or the fence
        bypass_take = bypass_path && enq && deq;
        store       = enq && !bypass_take;
        pop         = deq && !bypass_path;
    end

    assign out_ctrl   = head.ctrl;
    assign out_pc     = head.pc;
    assign out_excp   = head.excp;
    assign out_serial = head.serial;
    assign count      = count_reg;

    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        ser_block_next = ser_block_reg;

        if (store) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({store, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // The serial entry is always the youngest, so popping it lifts the fence
        if (pop && rd_entry.serial) begin
            ser_block_next = 1'b0;
        end
        if (store && in_serial) begin
            ser_block_next = 1'b1;
        end

        if (flush) begin
            rd_ptr_next    = '0;
            wr_ptr_next    = '0;
            count_next     = '0;
            ser_block_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            ser_block_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            ser_block_reg <= ser_block_next;
        end
    end

endmodule
